// File: rtl/yazmac_obegi.sv
// yazmac_obegi: integer register file with a per-register busy/tag scoreboard.
//
// Sits behind the writeback stage. Issue allocates one destination per cycle
// (marks it busy under the issuing uop's tag). Writeback stores data and clears
// busy only when its tag matches the youngest producer. Two combinational read
// ports bypass a tag-matching writeback in the same cycle. x0 reads as zero,
// is never busy and ignores writes/allocations.
//
// Ports:
//   clk_i, rstn_i                 clock, async active-low reset
//   okuN_adres_i                  read address (N = 1, 2)
//   okuN_veri_o/_gecerli_o/_etiket_o   read data, ready flag, pending producer tag
//   ayir_gecerli_i/_adres_i/_etiket_i  destination allocation from issue
//   yo_gecerli_i/_veri_i/_adres_i/_etiket_i  writeback commit stream
//   temizle_i                     flush: clear every busy bit
//   mesgul_sayisi_o               registered count of busy registers

// One read port: x0 forcing, writeback bypass, scoreboard status.
module yazmac_obegi_oku_port #(
    parameter int VERI_BIT      = 32,
    parameter int YAZMAC_SAYISI = 32,
    parameter int YAZMAC_BIT    = 5,
    parameter int UOP_TAG_BIT   = 4
) (
    input  logic [YAZMAC_BIT-1:0]                        adres_i,
    input  logic [YAZMAC_SAYISI-1:0][VERI_BIT-1:0]       veri_q_i,
    input  logic [YAZMAC_SAYISI-1:0]                     mesgul_q_i,
    input  logic [YAZMAC_SAYISI-1:0][UOP_TAG_BIT-1:0]    etiket_q_i,
    input  logic                                         yo_gecerli_i,
    input  logic [VERI_BIT-1:0]                          yo_veri_i,
    input  logic [YAZMAC_BIT-1:0]                        yo_adres_i,
    input  logic [UOP_TAG_BIT-1:0]                       yo_etiket_i,
    output logic [VERI_BIT-1:0]                          veri_o,
    output logic                                         gecerli_o,
    output logic [UOP_TAG_BIT-1:0]                       etiket_o
);
    logic atlama;

    always_comb begin
        veri_o    = '0;
        gecerli_o = 1'b1;
        etiket_o  = '0;
        atlama    = 1'b0;
        if (adres_i != '0) begin
            // Bypass only the writeback that actually retires the pending producer;
            // a stale-tag write must not make the register look ready.
            atlama    = yo_gecerli_i && (yo_adres_i == adres_i) && mesgul_q_i[adres_i]
                        && (etiket_q_i[adres_i] == yo_etiket_i);
            veri_o    = atlama ? yo_veri_i : veri_q_i[adres_i];
            gecerli_o = atlama || !mesgul_q_i[adres_i];
            etiket_o  = etiket_q_i[adres_i];
        end
    end
endmodule

module yazmac_obegi #(
    parameter int VERI_BIT      = 32,
    parameter int YAZMAC_SAYISI = 32,
    parameter int YAZMAC_BIT    = 5,
    parameter int UOP_TAG_BIT   = 4
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic [YAZMAC_BIT-1:0]   oku1_adres_i,
    output logic [VERI_BIT-1:0]     oku1_veri_o,
    output logic                    oku1_gecerli_o,
    output logic [UOP_TAG_BIT-1:0]  oku1_etiket_o,
    input  logic [YAZMAC_BIT-1:0]   oku2_adres_i,
    output logic [VERI_BIT-1:0]     oku2_veri_o,
    output logic                    oku2_gecerli_o,
    output logic [UOP_TAG_BIT-1:0]  oku2_etiket_o,
    input  logic                    ayir_gecerli_i,
    input  logic [YAZMAC_BIT-1:0]   ayir_adres_i,
    input  logic [UOP_TAG_BIT-1:0]  ayir_etiket_i,
    input  logic                    yo_gecerli_i,
    input  logic [VERI_BIT-1:0]     yo_veri_i,
    input  logic [YAZMAC_BIT-1:0]   yo_adres_i,
    input  logic [UOP_TAG_BIT-1:0]  yo_etiket_i,
    input  logic                    temizle_i,
    output logic [YAZMAC_BIT:0]     mesgul_sayisi_o
);
    localparam int NUM_PORTS = 2;

    logic [YAZMAC_SAYISI-1:0][VERI_BIT-1:0]    veri_q, veri_d;
    logic [YAZMAC_SAYISI-1:0]                  mesgul_q, mesgul_d;
    logic [YAZMAC_SAYISI-1:0][UOP_TAG_BIT-1:0] etiket_q, etiket_d;
    logic [YAZMAC_BIT:0]                       sayac_q, sayac_d;

    logic yo_yaz, yo_eslesme, ayir_ok, artir, azalt;

    always_comb begin
        yo_yaz     = yo_gecerli_i && (yo_adres_i != '0);
        yo_eslesme = yo_yaz && mesgul_q[yo_adres_i] && (etiket_q[yo_adres_i] == yo_etiket_i);
        ayir_ok    = ayir_gecerli_i && (ayir_adres_i != '0) && !temizle_i;
        // Counter moves by the net change in busy population; a clear and an
        // allocation to the same register cancel out.
        artir      = ayir_ok && !mesgul_q[ayir_adres_i];
        azalt      = yo_eslesme && !(ayir_ok && (ayir_adres_i == yo_adres_i));

        veri_d   = veri_q;
        mesgul_d = mesgul_q;
        etiket_d = etiket_q;
        sayac_d  = sayac_q;

        if (yo_yaz) begin
            veri_d[yo_adres_i] = yo_veri_i;
        end
        if (yo_eslesme) begin
            mesgul_d[yo_adres_i] = 1'b0;
        end
        // Allocation applied after the clear so it wins on the same register.
        if (ayir_ok) begin
            mesgul_d[ayir_adres_i] = 1'b1;
            etiket_d[ayir_adres_i] = ayir_etiket_i;
        end

        if (temizle_i) begin
            mesgul_d = '0;
            sayac_d  = '0;
        end else begin
            sayac_d = sayac_q + {{YAZMAC_BIT{1'b0}}, artir} - {{YAZMAC_BIT{1'b0}}, azalt};
        end
        mesgul_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            veri_q   <= '0;
            mesgul_q <= '0;
            etiket_q <= '0;
            sayac_q  <= '0;
        end else begin
            veri_q   <= veri_d;
            mesgul_q <= mesgul_d;
            etiket_q <= etiket_d;
            sayac_q  <= sayac_d;
        end
    end

    assign mesgul_sayisi_o = sayac_q;

    logic [NUM_PORTS-1:0][YAZMAC_BIT-1:0]  oku_adres;
    logic [NUM_PORTS-1:0][VERI_BIT-1:0]    oku_veri;
    logic [NUM_PORTS-1:0]                  oku_gecerli;
    logic [NUM_PORTS-1:0][UOP_TAG_BIT-1:0] oku_etiket;

    assign oku_adres = {oku2_adres_i, oku1_adres_i};

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_oku
        yazmac_obegi_oku_port #(
            .VERI_BIT      (VERI_BIT),
            .YAZMAC_SAYISI (YAZMAC_SAYISI),
            .YAZMAC_BIT    (YAZMAC_BIT),
            .UOP_TAG_BIT   (UOP_TAG_BIT)
        ) u_port (
            .adres_i      (oku_adres[p]),
            .veri_q_i     (veri_q),
            .mesgul_q_i   (mesgul_q),
            .etiket_q_i   (etiket_q),
            .yo_gecerli_i (yo_gecerli_i),
            .yo_veri_i    (yo_veri_i),
            .yo_adres_i   (yo_adres_i),
            .yo_etiket_i  (yo_etiket_i),
            .veri_o       (oku_veri[p]),
            .gecerli_o    (oku_gecerli[p]),
            .etiket_o     (oku_etiket[p])
        );
    end

    assign oku1_veri_o    = oku_veri[0];
    assign oku1_gecerli_o = oku_gecerli[0];
    assign oku1_etiket_o  = oku_etiket[0];
    assign oku2_veri_o    = oku_veri[1];
    assign oku2_gecerli_o = oku_gecerli[1];
    assign oku2_etiket_o  = oku_etiket[1];
endmodule
